// File: rtl/risc_run_pkg.sv
// Shared types and helpers for the RISC core run controller.
package risc_run_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RESET,
        ST_RUN,
        ST_DONE
    } run_state_t;

    // Bits needed to index n items; never less than one so that n = 1 still gets a port.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/risc_run_ctrl_if.sv
// Run-control handshake between a host sequencer and the RISC run controller.
interface risc_run_ctrl_if;

    logic start;
    logic abort;
    logic busy;
    logic done;
    logic timeout;

    modport master (output start, abort, input busy, done, timeout);
    modport slave  (input start, abort, output busy, done, timeout);

endinterface

// File: rtl/risc_halt_capture.sv
// One core's sticky halt flag plus the cycle count latched on its first halt.
module risc_halt_capture #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             cap_en,
    input  logic             halt,
    input  logic [CNT_W-1:0] cycles,
    output logic             flag,
    output logic [CNT_W-1:0] count
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag  <= 1'b0;
            count <= '0;
        end else if (clr) begin
            flag  <= 1'b0;
            count <= '0;
        end else if (cap_en && halt && !flag) begin
            flag  <= 1'b1;
            count <= cycles;
        end
    end

endmodule

// File: rtl/risc_run_ctrl.sv
// Sequences N_CORES RISC cores through reset and run, with per-core halt capture and a watchdog.
module risc_run_ctrl
    import risc_run_pkg::*;
#(
    parameter int    N_CORES    = 2,
    parameter int    CNT_W      = 32,
    parameter longint TIMEOUT   = 100000,
    parameter int    RST_CYCLES = 2,
    localparam int   SEL_W      = clog2_min1(N_CORES)
) (
    input  logic               clk,
    input  logic               rst_n,
    risc_run_ctrl_if.slave     ctl,
    input  logic [N_CORES-1:0] core_halt,
    output logic [N_CORES-1:0] core_rst_n,
    output logic [N_CORES-1:0] core_en,
    output logic [N_CORES-1:0] halted_mask,
    output logic [CNT_W-1:0]   cycles,
    input  logic [SEL_W-1:0]   rd_sel,
    output logic [CNT_W-1:0]   rd_cycles
);

    localparam int             RW         = clog2_min1(RST_CYCLES);
    localparam logic [RW-1:0]  RST_LAST   = RW'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(TIMEOUT - 1);

    run_state_t         state;
    logic [RW-1:0]      rst_cnt;
    logic               start_ok;
    logic               cap_en;
    logic [N_CORES-1:0] mask_next;
    logic               all_halted;
    logic [CNT_W-1:0]   counts [N_CORES];

    // Abort outranks a start request and suppresses halt captures in its cycle.
    assign start_ok   = ctl.start && !ctl.abort && (state == ST_IDLE || state == ST_DONE);
    assign cap_en     = (state == ST_RUN) && !ctl.abort;
    assign mask_next  = halted_mask | core_halt;
    assign all_halted = &mask_next;

    for (genvar i = 0; i < N_CORES; i++) begin : g_cap
        risc_halt_capture #(.CNT_W(CNT_W)) u_cap (
            .clk    (clk),
            .rst_n  (rst_n),
            .clr    (start_ok),
            .cap_en (cap_en),
            .halt   (core_halt[i]),
            .cycles (cycles),
            .flag   (halted_mask[i]),
            .count  (counts[i])
        );
    end

    // NOTE: the latched counts are individual flops with async reset, since software may read them right after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            rst_cnt     <= '0;
            core_rst_n  <= '0;
            core_en     <= '0;
            ctl.busy    <= 1'b0;
            ctl.done    <= 1'b0;
            ctl.timeout <= 1'b0;
            cycles      <= '0;
        end else begin
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    core_rst_n <= '1;
                    if (start_ok) begin
                        state       <= ST_RESET;
                        rst_cnt     <= '0;
                        core_rst_n  <= '0;
                        core_en     <= '0;
                        ctl.busy    <= 1'b1;
                        ctl.done    <= 1'b0;
                        ctl.timeout <= 1'b0;
                        cycles      <= '0;
                    end
                end
                ST_RESET: begin
                    if (ctl.abort) begin
                        state      <= ST_IDLE;
                        core_rst_n <= '1;
                        ctl.busy   <= 1'b0;
                    end else if (rst_cnt == RST_LAST) begin
                        state      <= ST_RUN;
                        core_rst_n <= '1;
                        core_en    <= '1;
                    end else begin
                        rst_cnt <= rst_cnt + RW'(1);
                    end
                end
                ST_RUN: begin
                    if (ctl.abort) begin
                        state    <= ST_IDLE;
                        core_en  <= '0;
                        ctl.busy <= 1'b0;
                    end else if (all_halted) begin
                        state    <= ST_DONE;
                        core_en  <= '0;
                        ctl.busy <= 1'b0;
                        ctl.done <= 1'b1;
                    end else if (cycles == LAST_CYCLE) begin
                        state       <= ST_DONE;
                        core_en     <= '0;
                        ctl.busy    <= 1'b0;
                        ctl.done    <= 1'b1;
                        ctl.timeout <= 1'b1;
                    end else begin
                        cycles  <= cycles + CNT_W'(1);
                        core_en <= ~mask_next;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: assign the default first so no path through the loop leaves rd_cycles unassigned (no latch).
    always_comb begin
        rd_cycles = '0;
        for (int i = 0; i < N_CORES; i++) begin
            if (rd_sel == SEL_W'(i)) rd_cycles = counts[i];
        end
    end

endmodule

// File: tb/tb_risc_run_ctrl.sv
// Randomized bench for risc_run_ctrl: each run is predicted from its halt/abort schedule alone.
module tb_risc_run_ctrl;

    localparam int N     = 2;
    localparam int CW    = 16;
    localparam int TMO   = 50;
    localparam int RC    = 2;
    localparam int NEVER = 1000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  core_halt;
    logic [N-1:0]  core_rst_n;
    logic [N-1:0]  core_en;
    logic [N-1:0]  halted_mask;
    logic [CW-1:0] cycles;
    logic [CW-1:0] rd_cycles;
    logic [0:0]    rd_sel;

    int n_cmp = 0;
    int n_bad = 0;

    risc_run_ctrl_if ctl_if ();

    risc_run_ctrl #(
        .N_CORES    (N),
        .CNT_W      (CW),
        .TIMEOUT    (TMO),
        .RST_CYCLES (RC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ctl         (ctl_if),
        .core_halt   (core_halt),
        .core_rst_n  (core_rst_n),
        .core_en     (core_en),
        .halted_mask (halted_mask),
        .cycles      (cycles),
        .rd_sel      (rd_sel),
        .rd_cycles   (rd_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag, input bit busy, input bit done, input bit tmo,
                                 input logic [N-1:0] rstn, input logic [N-1:0] en,
                                 input logic [N-1:0] mask, input int cyc);
        check({tag, ".busy"},    32'(ctl_if.busy),    32'(busy));
        check({tag, ".done"},    32'(ctl_if.done),    32'(done));
        check({tag, ".timeout"}, 32'(ctl_if.timeout), 32'(tmo));
        check({tag, ".rst_n"},   32'(core_rst_n),     32'(rstn));
        check({tag, ".en"},      32'(core_en),        32'(en));
        check({tag, ".mask"},    32'(halted_mask),    32'(mask));
        check({tag, ".cycles"},  32'(cycles),         32'(cyc));
    endtask

    task automatic check_counts(input string tag, input int c0, input int c1);
        rd_sel = 1'b0;
        #1 check({tag, ".count0"}, 32'(rd_cycles), 32'(c0));
        rd_sel = 1'b1;
        #1 check({tag, ".count1"}, 32'(rd_cycles), 32'(c1));
    endtask

    // Reference: a run is fully described by each core's halt cycle and an optional abort cycle.
    task automatic run_one(input string tag, input int h0, input int h1, input int ab_at, input bit noise);
        int           h [N];
        int           k;
        int           k_end;
        bit           ab;
        bit           fin;
        bit           all_done;
        bit           tmo;
        logic [N-1:0] m;
        int           c [N];
        h[0] = h0;
        h[1] = h1;
        ab   = 1'b0;
        ctl_if.start  = 1'b1;
        ctl_if.abort  = 1'b0;
        core_halt     = noise ? N'($urandom) : '0;
        step();
        ctl_if.start = 1'b0;
        for (int r = 0; r < RC; r++) begin
            check_outputs({tag, ".rst"}, 1'b1, 1'b0, 1'b0, '0, '0, '0, 0);
            if (r == 0) check_counts({tag, ".rst"}, 0, 0);
            core_halt    = noise ? N'($urandom) : '0;
            ctl_if.start = noise ? 1'($urandom) : 1'b0;
            step();
        end
        ctl_if.start = 1'b0;
        k_end = 0;
        for (k = 0; k <= TMO; k++) begin
            for (int i = 0; i < N; i++) m[i] = (h[i] < k);
            check_outputs({tag, ".run"}, 1'b1, 1'b0, 1'b0, '1, ~m, m, k);
            all_done = 1'b1;
            for (int i = 0; i < N; i++) begin
                core_halt[i] = (k >= h[i]);
                if (h[i] > k) all_done = 1'b0;
            end
            ab           = (k == ab_at);
            ctl_if.abort = ab;
            ctl_if.start = noise ? 1'($urandom) : 1'b0;
            fin          = ab || all_done || (k == TMO - 1);
            step();
            ctl_if.abort = 1'b0;
            ctl_if.start = 1'b0;
            k_end = k;
            if (fin) break;
        end
        tmo = !ab && !all_done;
        for (int i = 0; i < N; i++) begin
            m[i] = ab ? (h[i] < k_end) : (h[i] <= k_end);
            c[i] = m[i] ? h[i] : 0;
        end
        for (int t = 0; t < 3; t++) begin
            check_outputs({tag, ".end"}, 1'b0, !ab, tmo, '1, '0, m, k_end);
            if (t == 0) check_counts({tag, ".end"}, c[0], c[1]);
            core_halt = N'($urandom);
            step();
        end
        core_halt = '0;
    endtask

    initial begin
        int h0;
        int h1;
        int ab;
        ctl_if.start = 1'b0;
        ctl_if.abort = 1'b0;
        core_halt    = '0;
        rd_sel       = 1'b0;

        #2;
        check_outputs("por", 1'b0, 1'b0, 1'b0, '0, '0, '0, 0);
        check_counts("por", 0, 0);
        #8 rst_n = 1'b1;
        step();
        check_outputs("idle", 1'b0, 1'b0, 1'b0, '1, '0, '0, 0);

        run_one("halt_10_25", 10, 25, -1, 1'b0);
        run_one("watchdog", NEVER, NEVER, -1, 1'b0);
        run_one("halt_last", 3, TMO - 1, -1, 1'b0);
        run_one("abort_5", 2, NEVER, 5, 1'b0);

        ctl_if.start = 1'b1;
        ctl_if.abort = 1'b1;
        step();
        ctl_if.start = 1'b0;
        ctl_if.abort = 1'b0;
        check_outputs("start_abort_idle", 1'b0, 1'b0, 1'b0, '1, '0, 2'b01, 5);
        check_counts("start_abort_idle", 2, 0);

        ctl_if.start = 1'b1;
        step();
        ctl_if.start = 1'b0;
        ctl_if.abort = 1'b1;
        step();
        ctl_if.abort = 1'b0;
        check_outputs("abort_reset", 1'b0, 1'b0, 1'b0, '1, '0, '0, 0);

        run_one("same_cycle", 7, 7, -1, 1'b1);
        run_one("abort_last", NEVER, NEVER, TMO - 1, 1'b0);
        run_one("halt_zero", 0, 0, -1, 1'b1);

        for (int n = 0; n < 16; n++) begin
            h0 = $urandom_range(0, 60);
            h1 = $urandom_range(0, 60);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 55) : -1;
            if (ab == h0 || ab == h1) ab = -1;
            run_one($sformatf("rnd%0d", n), h0, h1, ab, 1'b1);
        end

        ctl_if.start = 1'b1;
        step();
        ctl_if.start = 1'b0;
        repeat (RC) step();
        core_halt = 2'b01;
        repeat (4) step();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_outputs("async_rst", 1'b0, 1'b0, 1'b0, '0, '0, '0, 0);
        check_counts("async_rst", 0, 0);
        core_halt = '0;
        #1 rst_n = 1'b1;
        step();
        check_outputs("post_rst", 1'b0, 1'b0, 1'b0, '1, '0, '0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
